// File: rtl/fa_pkg.sv
// Shared constants for the registered full-adder block.
package fa_pkg;

  localparam int unsigned FA_MIN_WIDTH = 1;
  localparam int unsigned FA_MAX_WIDTH = 64;

  // Value loaded into the sum register on reset, sliced to the instance width.
  localparam logic [FA_MAX_WIDTH-1:0] FA_RST_SUM = '0;

endpackage : fa_pkg

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder: the master drives operands, the slave returns results.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, s, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, s, cout
  );

endinterface : full_adder_if

// File: rtl/fa_cell.sv
// Single-bit combinational full adder, the basic arithmetic cell of the datapath.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin, one cycle after capture.
module full_adder
  import fa_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  full_adder_if.slave   bus
);

  // Reject widths outside the supported range at elaboration.
  if (WIDTH < FA_MIN_WIDTH || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  logic [WIDTH-1:0] sum_c;
  logic             carry_msb_c;

  // Ripple chain: each stage keeps its own carry nets so no vector feeds back on itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic cin_c;
    logic cout_c;

    if (i == 0) begin : g_first
      assign cin_c = bus.cin;
    end else begin : g_next
      assign cin_c = g_bit[i-1].cout_c;
    end

    fa_cell u_cell (
      .A    (bus.a[i]),
      .B    (bus.b[i]),
      .Cin  (cin_c),
      .S    (sum_c[i]),
      .Cout (cout_c)
    );
  end

  assign carry_msb_c = g_bit[WIDTH-1].cout_c;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  // Load a fresh result on valid input; otherwise hold the result and drop out_valid.
  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      s_d         = sum_c;
      cout_d      = carry_msb_c;
      out_valid_d = 1'b1;
    end
  end

  // Output register stage; reset clears any pending result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= WIDTH'(FA_RST_SUM);
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8 with hand-computed vectors.
module tb_full_adder;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  logic [1:0] q1 [$];  // {cout, s} expected from the 1-bit instance
  logic [8:0] q8 [$];  // {cout, s} expected from the 8-bit instance

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) u_fa1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  full_adder #(.WIDTH(8)) u_fa8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor for the 1-bit instance: a queued expectation must appear exactly now.
  logic [1:0] e1;
  always @(posedge clk) begin
    #1;
    n_vec++;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      if (bus1.out_valid !== 1'b1 || bus1.s !== e1[0] || bus1.cout !== e1[1]) begin
        n_err++;
        $display("FAIL w1_result: got valid=%b s=%b cout=%b required valid=1 s=%b cout=%b",
                 bus1.out_valid, bus1.s, bus1.cout, e1[0], e1[1]);
      end
    end else if (bus1.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL w1_idle: got valid=%b required valid=0", bus1.out_valid);
    end
  end

  // Monitor for the 8-bit instance.
  logic [8:0] e8;
  always @(posedge clk) begin
    #1;
    n_vec++;
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      if (bus8.out_valid !== 1'b1 || bus8.s !== e8[7:0] || bus8.cout !== e8[8]) begin
        n_err++;
        $display("FAIL w8_result: got valid=%b s=%h cout=%b required valid=1 s=%h cout=%b",
                 bus8.out_valid, bus8.s, bus8.cout, e8[7:0], e8[8]);
      end
    end else if (bus8.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL w8_idle: got valid=%b required valid=0", bus8.out_valid);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Present one operand set to the 1-bit instance on the falling edge.
  task automatic drv1(input logic v, input logic a, input logic b, input logic c,
                      input logic es, input logic ec);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus1.in_valid = v;
    bus1.a        = a;
    bus1.b        = b;
    bus1.cin      = c;
    if (v && rst_n) q1.push_back({ec, es});
  endtask

  // Present one operand set to the 8-bit instance on the falling edge.
  task automatic drv8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus8.in_valid = v;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = c;
    if (v && rst_n) q8.push_back({ec, es});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
    bus8.in_valid = 1'b1; bus8.a = 8'hA5; bus8.b = 8'h5A; bus8.cin = 1'b1;

    // Reset takes effect before any clock edge.
    #1;
    chk("rst_w1_s", 64'(bus1.s), 64'h0);
    chk("rst_w1_cout", 64'(bus1.cout), 64'h0);
    chk("rst_w1_valid", 64'(bus1.out_valid), 64'h0);
    chk("rst_w8_s", 64'(bus8.s), 64'h0);
    chk("rst_w8_cout", 64'(bus8.cout), 64'h0);
    chk("rst_w8_valid", 64'(bus8.out_valid), 64'h0);

    repeat (2) @(negedge clk);
    bus1.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    rst_n = 1'b1;

    // WIDTH=1 directed vectors.
    drv1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drv1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drv1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // WIDTH=1 full truth table, back to back.
    drv1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drv1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drv1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drv1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drv1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drv1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drv1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // WIDTH=8 carry chain and assorted patterns.
    drv8(1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    drv8(1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    drv8(1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    drv8(1'b1, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0);
    drv8(1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // Valid gating: result holds and out_valid drops.
    drv8(1'b1, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
    drv8(1'b0, 8'h09, 8'h09, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    chk("gate_s_hold", 64'(bus8.s), 64'h07);
    chk("gate_valid_low", 64'(bus8.out_valid), 64'h0);

    // Reset between two valid inputs.
    drv8(1'b1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s", 64'(bus8.s), 64'h0);
    chk("mid_rst_cout", 64'(bus8.cout), 64'h0);
    chk("mid_rst_valid", 64'(bus8.out_valid), 64'h0);
    drv8(1'b1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);  // sampled in reset, must be dropped
    @(negedge clk);
    rst_n = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.a        = 8'hC8;
    bus8.b        = 8'h64;
    bus8.cin      = 1'b0;
    q8.push_back({1'b1, 8'h2C});
    drv8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    chk("w1_queue_drained", 64'(q1.size()), 64'h0);
    chk("w8_queue_drained", 64'(q8.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_full_adder
